// File: rtl/uart_tx_ctrl_if.sv
// Requester-facing bundle of the UART transmit controller: configuration
// write port and the byte handshake.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 cfg_we;
    logic [31:0]          cfg_div;
    logic                 cfg_parity_en;
    logic                 cfg_parity_odd;
    logic                 cfg_two_stop;
    logic                 cfg_rej;
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (
        output cfg_we, cfg_div, cfg_parity_en, cfg_parity_odd, cfg_two_stop,
        output tx_valid, tx_data,
        input  cfg_rej, tx_ready
    );

    modport slave (
        input  cfg_we, cfg_div, cfg_parity_en, cfg_parity_odd, cfg_two_stop,
        input  tx_valid, tx_data,
        output cfg_rej, tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one word (start, LSB-first data, optional
// parity, one or two stop bits) paced by an external baud tick generator.
module uart_tx_ctrl #(
    parameter int          DATA_BITS   = 8,
    parameter logic [31:0] DEFAULT_DIV = 32'd433
) (
    input  logic                 clk,
    input  logic                 areset,
    uart_tx_ctrl_if.slave        bus,
    output logic [31:0]          baud_div,
    output logic                 baud_en,
    input  logic                 baud_tick,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] data,
                                          input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t               state_q, state_d;
    logic                 txd_q, txd_d;
    logic                 baud_en_q, baud_en_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 cfg_rej_q, cfg_rej_d;
    logic [31:0]          div_q, div_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 f_par_en_q, f_par_en_d;
    logic                 f_two_stop_q, f_two_stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 f_par_bit_q, f_par_bit_d;

    always_comb begin
        state_d      = state_q;
        txd_d        = txd_q;
        baud_en_d    = baud_en_q;
        tx_done_d    = 1'b0;
        cfg_rej_d    = 1'b0;
        div_d        = div_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        two_stop_d   = two_stop_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        f_par_en_d   = f_par_en_q;
        f_two_stop_d = f_two_stop_q;
        shift_d      = shift_q;
        f_par_bit_d  = f_par_bit_q;

        // Configuration only changes between frames; a write mid-frame is refused.
        if (bus.cfg_we) begin
            if (busy_q) begin
                cfg_rej_d = 1'b1;
            end else begin
                div_d      = bus.cfg_div;
                par_en_d   = bus.cfg_parity_en;
                par_odd_d  = bus.cfg_parity_odd;
                two_stop_d = bus.cfg_two_stop;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                txd_d     = 1'b1;
                baud_en_d = 1'b0;
                if (bus.tx_valid && tx_ready_q) begin
                    state_d      = S_START;
                    txd_d        = 1'b0;
                    baud_en_d    = 1'b1;
                    shift_d      = bus.tx_data;
                    f_par_bit_d  = frame_parity(bus.tx_data, par_odd_q);
                    f_par_en_d   = par_en_q;
                    f_two_stop_d = two_stop_q;
                    bit_cnt_d    = '0;
                    stop_cnt_d   = 1'b0;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                // shift_q[0] is the bit on the line; shift_q[1] is the next one.
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (f_par_en_q) begin
                            state_d = S_PARITY;
                            txd_d   = f_par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        txd_d     = shift_q[1];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_d    = S_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (baud_tick) begin
                    if (f_two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        baud_en_d = 1'b0;
                        tx_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                txd_d     = 1'b1;
                baud_en_d = 1'b0;
            end
        endcase

        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            txd_q        <= 1'b1;
            baud_en_q    <= 1'b0;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            cfg_rej_q    <= 1'b0;
            div_q        <= DEFAULT_DIV;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            two_stop_q   <= 1'b0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            f_par_en_q   <= 1'b0;
            f_two_stop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            txd_q        <= txd_d;
            baud_en_q    <= baud_en_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
            cfg_rej_q    <= cfg_rej_d;
            div_q        <= div_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            two_stop_q   <= two_stop_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            f_par_en_q   <= f_par_en_d;
            f_two_stop_q <= f_two_stop_d;
        end
    end

    // Frame payload is only consumed after acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q     <= shift_d;
        f_par_bit_q <= f_par_bit_d;
    end

    assign baud_div     = div_q;
    assign baud_en      = baud_en_q;
    assign txd          = txd_q;
    assign busy         = busy_q;
    assign tx_done      = tx_done_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.cfg_rej  = cfg_rej_q;

endmodule
